host_cfg_sequencer: RTL and testbench
=====================================

Name: host_cfg_sequencer

Overview:
Hardware replacement for hand-driven host configuration of the TCAD array. Context words (PE/LSU/SPM config, `CFG_W` bits each) are loaded over a narrow external write bus into an internal context store. On `start`, the block pulses `init`, then drives `host_controller` with contexts 0..`num_ctx`-1 in turn, holding each for a programmed cycle count while `run` is asserted. It sits between the host/ex_bus side and the TCAD top-level `host_controller`/`init`/`run` inputs.

Parameters:
CFG_W, 128, width of one context word (= `host_controller` width)
BUS_W, 32, load-bus data width
CTX_DEPTH, 16, number of context slots (power of 2)
INIT_CYC, 4, cycles `init` is held high before `run` (>=1)
HOLD_W, 8, width of per-context hold counter
BEATS (derived), ceil(CFG_W/BUS_W), data beats per context
CTX_AW (derived), clog2(CTX_DEPTH); BEAT_AW (derived), clog2(BEATS+1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
cfg_wen  in  1  load-bus write strobe
cfg_addr  in  CTX_AW+BEAT_AW  {ctx_idx, beat_idx}
cfg_wdata  in  BUS_W  write data
start  in  1  begin sequence (sampled when idle)
stop  in  1  abort sequence
num_ctx  in  CTX_AW+1  contexts to play (sampled with start)
host_controller  out  CFG_W  current context word
init  out  1  array init strobe
run  out  1  array run enable
busy  out  1  high in any state except IDLE
done  out  1  one-cycle completion pulse
cfg_err  out  1  sticky: write attempted while busy

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, context store and hold regs cleared to 0, cfg_err cleared.
- Load: on cfg_wen in IDLE, beat_idx b<BEATS writes cfg_wdata into bits [b*BUS_W +: BUS_W] of context ctx_idx (bits >=CFG_W dropped); b==BEATS writes cfg_wdata[HOLD_W-1:0] to hold[ctx_idx]; b>BEATS ignored. Write visible next cycle.
- cfg_wen while busy: write ignored, cfg_err set (sticky until reset).
- FSM IDLE -> INIT -> RUN -> DONE -> IDLE.
- IDLE: start=1 latches num_ctx; if latched value 0 -> DONE directly, else -> INIT. start ignored outside IDLE.
- INIT: init=1 for exactly INIT_CYC cycles; host_controller=0; then RUN.
- RUN: run=1, host_controller=ctx[k], k from 0; each context held max(hold[k],1) cycles (hold 0 treated as 1); after last context (k=num_ctx-1) -> DONE. num_ctx > CTX_DEPTH clamped to CTX_DEPTH.
- DONE: done=1 one cycle, run=0, host_controller=0, -> IDLE.
- Latency: start sampled at edge N -> init high cycles N+1..N+INIT_CYC, run high and host_controller=ctx0 from N+INIT_CYC+1.
- stop=1 in INIT or RUN: next cycle IDLE, run/init=0, host_controller=0, no done pulse. stop has priority over start and over normal transitions; ignored in IDLE/DONE.
- host_controller is registered; no combinational path from inputs to outputs.

Optional Feature:
Macro HOST_CFG_LOOP_EN. When defined: extra input `loop` (1 bit, sampled with start); if latched 1, after the last context RUN wraps to ctx0 without INIT or done, run stays high, until stop. When undefined: no `loop` port; always single pass as above.

Test Plan:
- Reset mid-RUN: assert rst=0 during ctx1 -> all outputs 0 immediately (async), FSM IDLE after release; context store reads back zeros on next run (host_controller=0).
- Load 3 contexts (CFG_W=128: 4 beats + hold), ctx0=0x...0001, hold={2,1,3}; start, num_ctx=3 -> init high 4 cycles, then ctx0 x2, ctx1 x1, ctx2 x3 cycles, done pulse 1 cycle, busy low after.
- hold[0]=0, num_ctx=1 -> ctx0 driven exactly 1 cycle; num_ctx=0 -> no init, no run, done 1 cycle after start.
- stop asserted on 2nd run cycle -> run/host_controller 0 next cycle, done never pulses; cfg_wen during RUN -> cfg_err=1, context unchanged.
- cfg_addr beat_idx=6 (>BEATS) write -> no context/hold change; start pulsed again while busy -> sequence timing unchanged.
- With HOST_CFG_LOOP_EN, loop=1, num_ctx=2, holds=1 -> ctx0,ctx1,ctx0,ctx1... with run continuously high until stop; no done.

Source files
------------

// File: rtl/host_cfg_sequencer_if.sv
// host_cfg_sequencer_if: load bus, sequence control and array-side outputs.
// master = host/ex_bus side, slave = sequencer. Optional `loop` with HOST_CFG_LOOP_EN.
interface host_cfg_sequencer_if #(
    parameter int CFG_W     = 128,
    parameter int BUS_W     = 32,
    parameter int CTX_DEPTH = 16
);
    localparam int BEATS   = (CFG_W + BUS_W - 1) / BUS_W;
    localparam int CTX_AW  = $clog2(CTX_DEPTH);
    localparam int BEAT_AW = $clog2(BEATS + 1);

    logic                      cfg_wen;
    logic [CTX_AW+BEAT_AW-1:0] cfg_addr;
    logic [BUS_W-1:0]          cfg_wdata;
    logic                      start;
    logic                      stop;
    logic [CTX_AW:0]           num_ctx;
`ifdef HOST_CFG_LOOP_EN
    logic                      loop;
`endif
    logic [CFG_W-1:0]          host_controller;
    logic                      init;
    logic                      run;
    logic                      busy;
    logic                      done;
    logic                      cfg_err;

    modport master (
`ifdef HOST_CFG_LOOP_EN
        output loop,
`endif
        output cfg_wen, cfg_addr, cfg_wdata,
        output start, stop, num_ctx,
        input  host_controller, init, run,
        input  busy, done, cfg_err
    );

    modport slave (
`ifdef HOST_CFG_LOOP_EN
        input  loop,
`endif
        input  cfg_wen, cfg_addr, cfg_wdata,
        input  start, stop, num_ctx,
        output host_controller, init, run,
        output busy, done, cfg_err
    );
endinterface

// File: rtl/host_cfg_sequencer.sv
// host_cfg_sequencer: loads context words over a narrow bus, then plays them
// to the TCAD host_controller with init/run. Ports: clk, rst (async, active-low),
// bus (host_cfg_sequencer_if.slave). Optional macro HOST_CFG_LOOP_EN adds looping.
module host_cfg_sequencer #(
    parameter int CFG_W     = 128,
    parameter int BUS_W     = 32,
    parameter int CTX_DEPTH = 16,
    parameter int INIT_CYC  = 4,
    parameter int HOLD_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    host_cfg_sequencer_if.slave  bus
);
    localparam int BEATS   = (CFG_W + BUS_W - 1) / BUS_W;
    localparam int CTX_AW  = $clog2(CTX_DEPTH);
    localparam int BEAT_AW = $clog2(BEATS + 1);
    localparam int NUM_W   = CTX_AW + 1;
    localparam int ROW_W   = BEATS * BUS_W;
    localparam int INIT_W  = $clog2(INIT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [CFG_W-1:0]    r_ctx  [CTX_DEPTH];
    logic [HOLD_W-1:0]   r_hold [CTX_DEPTH];
    logic [CTX_AW-1:0]   r_k;
    logic [CTX_AW-1:0]   r_last;
    logic [INIT_W-1:0]   r_init_cnt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [CFG_W-1:0]    r_host;
    logic                r_init;
    logic                r_run;
    logic                r_busy;
    logic                r_done;
    logic                r_cfg_err;
`ifdef HOST_CFG_LOOP_EN
    logic                r_loop;
`endif

    logic [CTX_AW-1:0]   w_ctx_idx;
    logic [BEAT_AW-1:0]  w_beat;
    logic [ROW_W-1:0]    w_row;
    logic                w_wr_ok;
    logic [NUM_W-1:0]    w_num_cl;
    logic [CTX_AW-1:0]   w_k_next;
    logic                w_loop;

    assign w_ctx_idx = bus.cfg_addr[CTX_AW+BEAT_AW-1 -: CTX_AW];
    assign w_beat    = bus.cfg_addr[BEAT_AW-1:0];
    assign w_wr_ok   = bus.cfg_wen && (r_state == S_IDLE);

    assign w_num_cl = (bus.num_ctx > NUM_W'(CTX_DEPTH)) ?
                      NUM_W'(CTX_DEPTH) : bus.num_ctx;

    // Wrap only matters when looping; single pass leaves RUN at r_last.
    assign w_k_next = (r_k == r_last) ? '0 : r_k + 1'b1;

`ifdef HOST_CFG_LOOP_EN
    assign w_loop = r_loop;
`else
    assign w_loop = 1'b0;
`endif

    // Merge one beat into the addressed row; bits past CFG_W fall off.
    always_comb begin
        w_row = '0;
        w_row[CFG_W-1:0] = r_ctx[w_ctx_idx];
        for (int b = 0; b < BEATS; b++) begin
            if (w_beat == BEAT_AW'(b)) begin
                w_row[b*BUS_W +: BUS_W] = bus.cfg_wdata;
            end
        end
    end

    // Hold 0 behaves as 1, so the down-counter starts at max(h,1)-1.
    function automatic logic [HOLD_W-1:0] hold_start(
        input logic [HOLD_W-1:0] h
    );
        return (h == '0) ? '0 : h - 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CTX_DEPTH; i++) begin
                r_ctx[i]  <= '0;
                r_hold[i] <= '0;
            end
            r_cfg_err <= 1'b0;
        end else begin
            if (bus.cfg_wen && (r_state != S_IDLE)) begin
                r_cfg_err <= 1'b1;
            end
            if (w_wr_ok) begin
                if (w_beat < BEAT_AW'(BEATS)) begin
                    r_ctx[w_ctx_idx] <= w_row[CFG_W-1:0];
                end else if (w_beat == BEAT_AW'(BEATS)) begin
                    r_hold[w_ctx_idx] <= bus.cfg_wdata[HOLD_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_last     <= '0;
            r_init_cnt <= '0;
            r_hold_cnt <= '0;
            r_host     <= '0;
            r_init     <= 1'b0;
            r_run      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef HOST_CFG_LOOP_EN
            r_loop     <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_last <= CTX_AW'(w_num_cl - 1'b1);
                        r_busy <= 1'b1;
`ifdef HOST_CFG_LOOP_EN
                        r_loop <= bus.loop;
`endif
                        if (w_num_cl == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_INIT;
                            r_init     <= 1'b1;
                            r_init_cnt <= INIT_W'(INIT_CYC - 1);
                        end
                    end
                end
                S_INIT: begin
                    if (bus.stop) begin
                        r_state <= S_IDLE;
                        r_init  <= 1'b0;
                        r_run   <= 1'b0;
                        r_host  <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_init_cnt == '0) begin
                        r_state    <= S_RUN;
                        r_init     <= 1'b0;
                        r_run      <= 1'b1;
                        r_k        <= '0;
                        r_host     <= r_ctx[0];
                        r_hold_cnt <= hold_start(r_hold[0]);
                    end else begin
                        r_init_cnt <= r_init_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.stop) begin
                        r_state <= S_IDLE;
                        r_init  <= 1'b0;
                        r_run   <= 1'b0;
                        r_host  <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_hold_cnt != '0) begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end else if ((r_k == r_last) && !w_loop) begin
                        r_state <= S_DONE;
                        r_run   <= 1'b0;
                        r_host  <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_k        <= w_k_next;
                        r_host     <= r_ctx[w_k_next];
                        r_hold_cnt <= hold_start(r_hold[w_k_next]);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.host_controller = r_host;
    assign bus.init            = r_init;
    assign bus.run             = r_run;
    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.cfg_err         = r_cfg_err;
endmodule

// File: tb/tb_host_cfg_sequencer.sv
// tb_host_cfg_sequencer: scoreboard bench for host_cfg_sequencer.
// Expected per-cycle outputs are queued at start and popped on each negedge.
module tb_host_cfg_sequencer;
    localparam int CFG_W     = 128;
    localparam int BUS_W     = 32;
    localparam int CTX_DEPTH = 16;
    localparam int INIT_CYC  = 4;
    localparam int HOLD_W    = 8;
    localparam int BEATS     = 4;

    typedef struct {
        logic             init;
        logic             run;
        logic             done;
        logic             busy;
        logic [CFG_W-1:0] hc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    host_cfg_sequencer_if #(
        .CFG_W(CFG_W), .BUS_W(BUS_W), .CTX_DEPTH(CTX_DEPTH)
    ) bus_if ();

    host_cfg_sequencer #(
        .CFG_W(CFG_W), .BUS_W(BUS_W), .CTX_DEPTH(CTX_DEPTH),
        .INIT_CYC(INIT_CYC), .HOLD_W(HOLD_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    exp_t             q[$];
    logic [CFG_W-1:0] m_ctx  [CTX_DEPTH];
    logic [HOLD_W-1:0] m_hold [CTX_DEPTH];
    int               n_chk  = 0;
    int               n_fail = 0;

    task automatic clear_model();
        for (int i = 0; i < CTX_DEPTH; i++) begin
            m_ctx[i]  = '0;
            m_hold[i] = '0;
        end
    endtask

    task automatic push(input logic i, input logic r, input logic d,
                        input logic b, input logic [CFG_W-1:0] h);
        exp_t e;
        e.init = i; e.run = r; e.done = d; e.busy = b; e.hc = h;
        q.push_back(e);
    endtask

    task automatic gen_seq(input int n, input bit lp);
        int nc;
        nc = (n > CTX_DEPTH) ? CTX_DEPTH : n;
        if (nc == 0) begin
            push(0, 0, 1, 1, '0);
            push(0, 0, 0, 0, '0);
            return;
        end
        for (int i = 0; i < INIT_CYC; i++) push(1, 0, 0, 1, '0);
        if (lp) begin
            for (int i = 0; i < 16; i++) push(0, 1, 0, 1, m_ctx[i % nc]);
            return;
        end
        for (int k = 0; k < nc; k++) begin
            int h;
            h = (m_hold[k] == 0) ? 1 : int'(m_hold[k]);
            for (int j = 0; j < h; j++) push(0, 1, 0, 1, m_ctx[k]);
        end
        push(0, 0, 1, 1, '0);
        push(0, 0, 0, 0, '0);
    endtask

    task automatic write_word(input int ctx, input int beat,
                              input logic [BUS_W-1:0] d);
        @(negedge clk);
        bus_if.cfg_wen   = 1'b1;
        bus_if.cfg_addr  = {4'(ctx), 3'(beat)};
        bus_if.cfg_wdata = d;
        @(negedge clk);
        bus_if.cfg_wen   = 1'b0;
        if (beat < BEATS) m_ctx[ctx][beat*BUS_W +: BUS_W] = d;
        else if (beat == BEATS) m_hold[ctx] = d[HOLD_W-1:0];
    endtask

    task automatic load_ctx(input int k, input logic [CFG_W-1:0] v,
                            input int h);
        for (int b = 0; b < BEATS; b++) write_word(k, b, v[b*BUS_W +: BUS_W]);
        write_word(k, BEATS, BUS_W'(h));
    endtask

    task automatic play(input string tag, input int n, input bit lp,
                        input int stop_at, input int wen_at,
                        input int start_at, input int rst_at);
        int c;
        bit hit_rst;
        exp_t e;
        q.delete();
        gen_seq(n, lp);
        c = 0;
        hit_rst = 0;
        @(negedge clk);
        bus_if.start   = 1'b1;
        bus_if.num_ctx = 5'(n);
`ifdef HOST_CFG_LOOP_EN
        bus_if.loop    = lp;
`endif
        while (q.size() != 0 && c < 300) begin
            @(negedge clk);
            bus_if.start   = 1'b0;
            bus_if.stop    = 1'b0;
            bus_if.cfg_wen = 1'b0;
            e = q.pop_front();
            n_chk++;
            if ({bus_if.init, bus_if.run, bus_if.done, bus_if.busy} !==
                {e.init, e.run, e.done, e.busy} ||
                bus_if.host_controller !== e.hc) begin
                n_fail++;
                $display("FAIL %s cyc %0d: got i/r/d/b=%b%b%b%b hc=%h, want %b%b%b%b hc=%h",
                         tag, c, bus_if.init, bus_if.run, bus_if.done,
                         bus_if.busy, bus_if.host_controller,
                         e.init, e.run, e.done, e.busy, e.hc);
            end
            if (c == rst_at) begin
                rst = 1'b0;
                #1;
                n_chk++;
                if ({bus_if.init, bus_if.run, bus_if.done, bus_if.busy,
                     bus_if.cfg_err} !== 5'b0 ||
                    bus_if.host_controller !== '0) begin
                    n_fail++;
                    $display("FAIL %s async_reset: got i/r/d/b/e=%b%b%b%b%b hc=%h, want 00000 hc=0",
                             tag, bus_if.init, bus_if.run, bus_if.done,
                             bus_if.busy, bus_if.cfg_err,
                             bus_if.host_controller);
                end
                q.delete();
                hit_rst = 1;
            end
            if (c == stop_at) begin
                bus_if.stop = 1'b1;
                q.delete();
                push(0, 0, 0, 0, '0);
            end
            if (c == wen_at) begin
                bus_if.cfg_wen   = 1'b1;
                bus_if.cfg_addr  = {4'd1, 3'd0};
                bus_if.cfg_wdata = 32'hFFFF_FFFF;
            end
            if (c == start_at) begin
                bus_if.start   = 1'b1;
                bus_if.num_ctx = 5'd1;
            end
            c++;
        end
        bus_if.start = 1'b0;
        bus_if.stop  = 1'b0;
        if (!hit_rst && q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s timeout: %0d expected cycles left, want 0",
                     tag, q.size());
        end
    endtask

    task automatic test_reset();
        n_chk++;
        if ({bus_if.init, bus_if.run, bus_if.done, bus_if.busy,
             bus_if.cfg_err} !== 5'b0 || bus_if.host_controller !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got i/r/d/b/e=%b%b%b%b%b hc=%h, want 00000 hc=0",
                     bus_if.init, bus_if.run, bus_if.done, bus_if.busy,
                     bus_if.cfg_err, bus_if.host_controller);
        end
    endtask

    task automatic test_basic();
        load_ctx(0, 128'h1, 2);
        load_ctx(1, 128'hA5A5_0000_1234_5678_9ABC_DEF0_0F0F_F0F0, 1);
        load_ctx(2, {$urandom, $urandom, $urandom, $urandom}, 3);
        play("basic3", 3, 0, -1, -1, -1, -1);
    endtask

    task automatic test_hold_zero();
        write_word(0, BEATS, 32'h0);
        play("hold0_n1", 1, 0, -1, -1, -1, -1);
        play("num_ctx0", 0, 0, -1, -1, -1, -1);
    endtask

    task automatic test_ignore_beat();
        write_word(0, 6, 32'hDEAD_BEEF);
        write_word(1, 5, 32'h0000_0007);
        play("beat_gt", 3, 0, -1, -1, -1, -1);
    endtask

    task automatic test_restart_busy();
        play("start_busy_init", 3, 0, -1, -1, 2, -1);
        play("start_busy_run", 3, 0, -1, -1, 5, -1);
    endtask

    task automatic test_stop();
        play("stop_run2", 3, 0, 5, -1, -1, -1);
        play("stop_init", 3, 0, 1, -1, -1, -1);
        n_chk++;
        if (bus_if.cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_quiet: got %b, want 0", bus_if.cfg_err);
        end
    endtask

    task automatic test_cfg_err();
        play("wen_in_run", 3, 0, -1, 4, -1, -1);
        n_chk++;
        if (bus_if.cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_err_set: got %b, want 1", bus_if.cfg_err);
        end
        play("ctx_kept", 3, 0, -1, -1, -1, -1);
        n_chk++;
        if (bus_if.cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_err_sticky: got %b, want 1", bus_if.cfg_err);
        end
    endtask

    task automatic test_clamp();
        load_ctx(15, 128'hFEED_0000_0000_0000_0000_0000_0000_BEEF, 2);
        play("clamp20", 20, 0, -1, -1, -1, -1);
        play("full16", 16, 0, -1, -1, -1, -1);
    endtask

`ifdef HOST_CFG_LOOP_EN
    task automatic test_loop();
        write_word(0, BEATS, 32'd1);
        write_word(1, BEATS, 32'd1);
        play("loop2", 2, 1, 11, -1, -1, -1);
    endtask
`endif

    task automatic test_reset_mid_run();
        load_ctx(0, 128'h1, 2);
        load_ctx(1, 128'h2222, 1);
        load_ctx(2, 128'h3333, 3);
        play("rst_mid", 3, 0, -1, -1, -1, 6);
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        play("after_rst", 3, 0, -1, -1, -1, -1);
    endtask

    initial begin
        bus_if.cfg_wen   = 1'b0;
        bus_if.cfg_addr  = '0;
        bus_if.cfg_wdata = '0;
        bus_if.start     = 1'b0;
        bus_if.stop      = 1'b0;
        bus_if.num_ctx   = '0;
`ifdef HOST_CFG_LOOP_EN
        bus_if.loop      = 1'b0;
`endif
        clear_model();
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_hold_zero();
        test_ignore_beat();
        test_restart_busy();
        test_stop();
        test_cfg_err();
        test_clamp();
`ifdef HOST_CFG_LOOP_EN
        test_loop();
`endif
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
